swu_stream_checker: RTL and testbench
=====================================

# swu_stream_checker

Self-checking AXI-Stream sink for the sliding window unit (SWU) output port, and the receiving end of the SWU datapath in block-level and on-board loopback benches. It optionally applies pseudo-random backpressure and consumes SIMD-wide window beats. Each beat is compared against the value expected when the SWU input is fed the canonical ramp pattern, where element (y, x, c) = ((y·IFMWidth + x)·IFMChannels + c) mod 2^IP_PRECISION. It reports mismatches, per-frame completion and cumulative counts.

## Interface
Parameters:
- SIMD, 1, lanes per beat; IFMChannels must be a multiple of SIMD
- IP_PRECISION, 8, bits per lane
- IFMChannels, 2, input channels
- IFMWidth / IFMHeight, 6 / 6, input feature map size
- KERNEL_WIDTH / KERNEL_HEIGHT, 3 / 3, window size
- STRIDE, 2, window stride (both axes)
- PADDING_WIDTH / PADDING_HEIGHT, 0 / 0, zero border per side
- OFMWidth / OFMHeight, 2 / 2, output map size
- STALL_EN, 1, 1 = LFSR-driven tready; 0 = tready held high after reset
- LFSR_SEED, 16'hACE1, nonzero backpressure LFSR seed

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ip_axis_tdata  in  SIMD·IP_PRECISION  window beat; lane s occupies bits [s·IP_PRECISION +: IP_PRECISION]
- ip_axis_tvalid  in  1  beat valid
- ip_axis_tready  out  1  beat accepted when tvalid && tready
- mismatch  out  1  one-cycle pulse per bad beat
- error_count  out  32  saturating count of bad beats
- first_err_idx  out  32  beat index within the frame of the first error since reset; all-ones if none
- frame_done  out  1  one-cycle pulse when a frame's last beat is accepted
- frame_count  out  16  completed frames, wraps

## Operation
- Beat order per frame, outermost to innermost: oy, ox, ky, kx, f. Here f = channel fold, 0..IFMChannels/SIMD−1. Lane s of a beat carries channel c = f·SIMD + s.
- BEATS = OFMHeight·OFMWidth·KERNEL_HEIGHT·KERNEL_WIDTH·(IFMChannels/SIMD). Default BEATS = 72.
- Source coordinates: y = oy·STRIDE + ky − PADDING_HEIGHT and x = ox·STRIDE + kx − PADDING_WIDTH, evaluated as signed values.
- Expected lane value:
  - 0 if y or x is outside the input map;
  - otherwise ((y·IFMWidth + x)·IFMChannels + c) mod 2^IP_PRECISION.
- The base index y·IFMWidth + x is maintained incrementally by nested counters with adders; no per-beat multipliers. Counters are 32-bit and are truncated to IP_PRECISION only at compare.
- A beat is bad if any lane differs from its expected value.
- Nested counters advance only on an accepted beat. After the last beat of a frame (all counters at maximum), every counter wraps to 0 and checking continues seamlessly into the next frame.
- Backpressure:
  - 16-bit Fibonacci LFSR with taps 16, 14, 13, 11; it steps every cycle.
  - With STALL_EN=1, ip_axis_tready = LFSR[0] | LFSR[1], which gives roughly 75 % ready.
  - With STALL_EN=0, tready is constant 1 after reset.
- tready is registered and does not depend combinationally on tvalid.
- error_count saturates at 32'hFFFF_FFFF.
- first_err_idx latches only while it is all-ones.

## Timing
- Reset (reset=1 at a clk edge):
  - ip_axis_tready = 0 during reset;
  - mismatch = 0, frame_done = 0, error_count = 0, frame_count = 0, first_err_idx = all-ones;
  - all counters = 0; LFSR = LFSR_SEED.
- First cycle after reset deasserts: tready follows the rule above, using the seed state.
- Handshake occurs on a clk edge where tvalid && tready. tdata is sampled on that edge only.
- Latency:
  - mismatch, error_count and first_err_idx update one cycle after the accepting edge.
  - frame_done pulses in that same cycle, and frame_count increments in that same cycle.
- Last beat bad: mismatch and frame_done pulse in the same cycle, and both are reported.
- Back-to-back beats at full rate (tready=1, tvalid=1) are checked every cycle with no bubbles.
- tvalid high while tready is low: nothing is consumed and the counters hold.
- Reset mid-frame: the partial frame is discarded, counters return to 0, and the next accepted beat is treated as beat 0 of a new frame.

## Test plan
- Defaults, STALL_EN=0, ideal ramp driven directly:
  - beats 0..3 are 0, 1, 2, 3;
  - beat 6 (ky=1) is 12;
  - beat 18 (ox=1) is 4;
  - after 72 beats: frame_done pulses once, frame_count=1, error_count=0.
- Same stream with beat 5 corrupted (0x05 → 0x55):
  - mismatch pulses exactly once, one cycle after that beat is accepted;
  - error_count=1, first_err_idx=5.
- STALL_EN=1, tvalid held high, three frames:
  - tready toggles according to the LFSR;
  - frame_count=3 and error_count=0 only if the stream was correct.
- PADDING_WIDTH=PADDING_HEIGHT=1, OFM 3×3, correct stream:
  - beat 0 (y=−1) is expected to be 0, and a nonzero value there is flagged;
  - beat 8 (ky=1, kx=1, y=x=0) is expected to be 0 and beat 9 to be 1.
- Reset asserted after 40 beats, then a fresh ramp is sent: no mismatch, and frame_done follows the next 72 beats.
- SIMD=2, IFMChannels=4: lane 1 of beat 0 is expected to be 1, and beat 1 lanes are expected to be 2 and 3.

Source files
------------

// File: rtl/swu_stream_checker.sv
// Self-checking AXI-Stream sink for the sliding window unit output.
// Consumes SIMD-wide window beats and compares each lane against the ramp pattern
// ((y*IFMWidth + x)*IFMChannels + c) mod 2^IP_PRECISION, with zero outside the input map.
// Optional LFSR-driven backpressure.
//
// Ports:
//   clk            clock
//   reset          synchronous active-high reset
//   ip_axis_tdata  window beat, lane s at [s*IP_PRECISION +: IP_PRECISION]
//   ip_axis_tvalid beat valid
//   ip_axis_tready registered ready (independent of tvalid)
//   mismatch       one-cycle pulse per bad beat
//   error_count    saturating count of bad beats
//   first_err_idx  in-frame index of the first bad beat since reset, all-ones if none
//   frame_done     one-cycle pulse when a frame's last beat is accepted
//   frame_count    completed frames, wraps
module swu_stream_checker #(
  parameter int unsigned SIMD           = 1,
  parameter int unsigned IP_PRECISION   = 8,
  parameter int unsigned IFMChannels    = 2,
  parameter int unsigned IFMWidth       = 6,
  parameter int unsigned IFMHeight      = 6,
  parameter int unsigned KERNEL_WIDTH   = 3,
  parameter int unsigned KERNEL_HEIGHT  = 3,
  parameter int unsigned STRIDE         = 2,
  parameter int unsigned PADDING_WIDTH  = 0,
  parameter int unsigned PADDING_HEIGHT = 0,
  parameter int unsigned OFMWidth       = 2,
  parameter int unsigned OFMHeight      = 2,
  parameter bit          STALL_EN       = 1'b1,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [SIMD*IP_PRECISION-1:0] ip_axis_tdata,
  input  logic                         ip_axis_tvalid,
  output logic                         ip_axis_tready,
  output logic                         mismatch,
  output logic [31:0]                  error_count,
  output logic [31:0]                  first_err_idx,
  output logic                         frame_done,
  output logic [15:0]                  frame_count
);

  localparam int unsigned Folds = IFMChannels / SIMD;

  // Signed geometry constants; indices below are pre-scaled by IFMChannels.
  localparam int YInit   = -int'(PADDING_HEIGHT);
  localparam int XInit   = -int'(PADDING_WIDTH);
  localparam int IdxInit = (YInit * int'(IFMWidth) + XInit) * int'(IFMChannels);
  localparam int RowStep = int'(IFMWidth) * int'(IFMChannels);
  localparam int OxStep  = int'(STRIDE) * int'(IFMChannels);
  localparam int OyStep  = int'(STRIDE) * int'(IFMWidth) * int'(IFMChannels);

  // Nested beat counters
  logic [31:0] f_q, f_d, kx_q, kx_d, ky_q, ky_d, ox_q, ox_d, oy_q, oy_d;
  logic [31:0] beat_q, beat_d;

  // Source coordinates of the current beat and of the window origin
  logic signed [31:0] y_org_q, y_org_d, x_org_q, x_org_d, y_q, y_d, x_q, x_d;

  // Channel-scaled element indices: row start at oy origin, window origin,
  // current kernel row start, and lane 0 of the current beat.
  logic signed [31:0] oy_base_q, oy_base_d, org_q, org_d, row_q, row_d, cur_q, cur_d;

  logic        ready_q, ready_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        mismatch_q, mismatch_d;
  logic        frame_done_q, frame_done_d;
  logic [31:0] error_count_q, error_count_d;
  logic [31:0] first_err_q, first_err_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic accept;
  logic last_f, last_kx, last_ky, last_ox, last_oy, last_beat;
  logic in_map, bad;
  logic [IP_PRECISION-1:0] exp_lane;

  assign accept    = ip_axis_tvalid & ready_q;
  assign last_f    = (f_q  == 32'(Folds - 1));
  assign last_kx   = (kx_q == 32'(KERNEL_WIDTH - 1));
  assign last_ky   = (ky_q == 32'(KERNEL_HEIGHT - 1));
  assign last_ox   = (ox_q == 32'(OFMWidth - 1));
  assign last_oy   = (oy_q == 32'(OFMHeight - 1));
  assign last_beat = last_f & last_kx & last_ky & last_ox & last_oy;

  // Beat comparison
  always_comb begin
    bad      = 1'b0;
    exp_lane = '0;
    in_map   = (y_q >= 0) && (y_q < int'(IFMHeight)) && (x_q >= 0) && (x_q < int'(IFMWidth));
    for (int s = 0; s < int'(SIMD); s++) begin
      exp_lane = in_map ? IP_PRECISION'(cur_q + s) : '0;
      if (ip_axis_tdata[s*IP_PRECISION +: IP_PRECISION] != exp_lane) begin
        bad = 1'b1;
      end
    end
  end

  // Counter advance on accepted beats
  always_comb begin
    f_d       = f_q;
    kx_d      = kx_q;
    ky_d      = ky_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    beat_d    = beat_q;
    y_org_d   = y_org_q;
    x_org_d   = x_org_q;
    y_d       = y_q;
    x_d       = x_q;
    oy_base_d = oy_base_q;
    org_d     = org_q;
    row_d     = row_q;
    cur_d     = cur_q;
    if (accept) begin
      beat_d = last_beat ? 32'd0 : beat_q + 32'd1;
      if (!last_f) begin
        f_d   = f_q + 32'd1;
        cur_d = cur_q + int'(SIMD);
      end else if (!last_kx) begin
        // The last fold of a pixel ends exactly SIMD short of the next pixel.
        f_d   = '0;
        kx_d  = kx_q + 32'd1;
        x_d   = x_q + 1;
        cur_d = cur_q + int'(SIMD);
      end else if (!last_ky) begin
        f_d   = '0;
        kx_d  = '0;
        ky_d  = ky_q + 32'd1;
        x_d   = x_org_q;
        y_d   = y_q + 1;
        row_d = row_q + RowStep;
        cur_d = row_q + RowStep;
      end else if (!last_ox) begin
        f_d     = '0;
        kx_d    = '0;
        ky_d    = '0;
        ox_d    = ox_q + 32'd1;
        x_org_d = x_org_q + int'(STRIDE);
        x_d     = x_org_q + int'(STRIDE);
        y_d     = y_org_q;
        org_d   = org_q + OxStep;
        row_d   = org_q + OxStep;
        cur_d   = org_q + OxStep;
      end else if (!last_oy) begin
        f_d       = '0;
        kx_d      = '0;
        ky_d      = '0;
        ox_d      = '0;
        oy_d      = oy_q + 32'd1;
        x_org_d   = XInit;
        x_d       = XInit;
        y_org_d   = y_org_q + int'(STRIDE);
        y_d       = y_org_q + int'(STRIDE);
        oy_base_d = oy_base_q + OyStep;
        org_d     = oy_base_q + OyStep;
        row_d     = oy_base_q + OyStep;
        cur_d     = oy_base_q + OyStep;
      end else begin
        f_d       = '0;
        kx_d      = '0;
        ky_d      = '0;
        ox_d      = '0;
        oy_d      = '0;
        x_org_d   = XInit;
        x_d       = XInit;
        y_org_d   = YInit;
        y_d       = YInit;
        oy_base_d = IdxInit;
        org_d     = IdxInit;
        row_d     = IdxInit;
        cur_d     = IdxInit;
      end
    end
  end

  // Status, backpressure
  always_comb begin
    mismatch_d    = accept & bad;
    frame_done_d  = accept & last_beat;
    frame_count_d = (accept & last_beat) ? frame_count_q + 16'd1 : frame_count_q;
    error_count_d = error_count_q;
    first_err_d   = first_err_q;
    if (accept && bad) begin
      if (error_count_q != '1) begin
        error_count_d = error_count_q + 32'd1;
      end
      if (first_err_q == '1) begin
        first_err_d = beat_q;
      end
    end
    // Fibonacci LFSR, taps 16,14,13,11 in right-shift form
    lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    ready_d = STALL_EN ? (lfsr_q[0] | lfsr_q[1]) : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_q           <= '0;
      kx_q          <= '0;
      ky_q          <= '0;
      ox_q          <= '0;
      oy_q          <= '0;
      beat_q        <= '0;
      y_org_q       <= YInit;
      x_org_q       <= XInit;
      y_q           <= YInit;
      x_q           <= XInit;
      oy_base_q     <= IdxInit;
      org_q         <= IdxInit;
      row_q         <= IdxInit;
      cur_q         <= IdxInit;
      ready_q       <= 1'b0;
      lfsr_q        <= LFSR_SEED;
      mismatch_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      error_count_q <= '0;
      first_err_q   <= '1;
      frame_count_q <= '0;
    end else begin
      f_q           <= f_d;
      kx_q          <= kx_d;
      ky_q          <= ky_d;
      ox_q          <= ox_d;
      oy_q          <= oy_d;
      beat_q        <= beat_d;
      y_org_q       <= y_org_d;
      x_org_q       <= x_org_d;
      y_q           <= y_d;
      x_q           <= x_d;
      oy_base_q     <= oy_base_d;
      org_q         <= org_d;
      row_q         <= row_d;
      cur_q         <= cur_d;
      ready_q       <= ready_d;
      lfsr_q        <= lfsr_d;
      mismatch_q    <= mismatch_d;
      frame_done_q  <= frame_done_d;
      error_count_q <= error_count_d;
      first_err_q   <= first_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign ip_axis_tready = ready_q;
  assign mismatch       = mismatch_q;
  assign frame_done     = frame_done_q;
  assign error_count    = error_count_q;
  assign first_err_idx  = first_err_q;
  assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_swu_stream_checker.sv
// Directed bench for swu_stream_checker: default geometry, LFSR backpressure,
// padded geometry and SIMD=2, all sharing one clock and reset.
module tb_swu_stream_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: defaults, no stall
  logic [7:0]  a_data = '0;
  logic        a_valid = 1'b0;
  logic        a_ready, a_mis, a_done;
  logic [31:0] a_err, a_first;
  logic [15:0] a_fc;
  // B: defaults, LFSR stall
  logic [7:0]  b_data = '0;
  logic        b_valid = 1'b0;
  logic        b_ready, b_mis, b_done;
  logic [31:0] b_err, b_first;
  logic [15:0] b_fc;
  // C: padding 1, OFM 3x3
  logic [7:0]  c_data = '0;
  logic        c_valid = 1'b0;
  logic        c_ready, c_mis, c_done;
  logic [31:0] c_err, c_first;
  logic [15:0] c_fc;
  // D: SIMD 2, 4 channels
  logic [15:0] d_data = '0;
  logic        d_valid = 1'b0;
  logic        d_ready, d_mis, d_done;
  logic [31:0] d_err, d_first;
  logic [15:0] d_fc;

  swu_stream_checker #(.STALL_EN(1'b0)) u_a (
    .clk(clk), .reset(rst), .ip_axis_tdata(a_data), .ip_axis_tvalid(a_valid),
    .ip_axis_tready(a_ready), .mismatch(a_mis), .error_count(a_err),
    .first_err_idx(a_first), .frame_done(a_done), .frame_count(a_fc)
  );

  swu_stream_checker #(.STALL_EN(1'b1)) u_b (
    .clk(clk), .reset(rst), .ip_axis_tdata(b_data), .ip_axis_tvalid(b_valid),
    .ip_axis_tready(b_ready), .mismatch(b_mis), .error_count(b_err),
    .first_err_idx(b_first), .frame_done(b_done), .frame_count(b_fc)
  );

  swu_stream_checker #(
    .STALL_EN(1'b0), .PADDING_WIDTH(1), .PADDING_HEIGHT(1), .OFMWidth(3), .OFMHeight(3)
  ) u_c (
    .clk(clk), .reset(rst), .ip_axis_tdata(c_data), .ip_axis_tvalid(c_valid),
    .ip_axis_tready(c_ready), .mismatch(c_mis), .error_count(c_err),
    .first_err_idx(c_first), .frame_done(c_done), .frame_count(c_fc)
  );

  swu_stream_checker #(.STALL_EN(1'b0), .SIMD(2), .IFMChannels(4)) u_d (
    .clk(clk), .reset(rst), .ip_axis_tdata(d_data), .ip_axis_tvalid(d_valid),
    .ip_axis_tready(d_ready), .mismatch(d_mis), .error_count(d_err),
    .first_err_idx(d_first), .frame_done(d_done), .frame_count(d_fc)
  );

  // Backpressure reference for u_b
  logic [15:0] lfsr_m = 16'hACE1;
  logic        exp_rdy_b = 1'b0;

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      lfsr_m    = 16'hACE1;
      exp_rdy_b = 1'b0;
    end else begin
      exp_rdy_b = lfsr_m[0] | lfsr_m[1];
      lfsr_m    = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    end
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ramp value, 3x3 kernel, 6x6 input
  function automatic logic [7:0] ramp(input int simd, input int ch, input int s, input int pw,
                                      input int ph, input int ow, input int beat,
                                      input int lane);
    int folds, f, kx, ky, ox, oy, t, y, x, v;
    folds = ch / simd;
    f  = beat % folds;  t = beat / folds;
    kx = t % 3;         t = t / 3;
    ky = t % 3;         t = t / 3;
    ox = t % ow;        oy = t / ow;
    y  = oy * s + ky - ph;
    x  = ox * s + kx - pw;
    if (y < 0 || y >= 6 || x < 0 || x >= 6) v = 0;
    else v = (y * 6 + x) * ch + f * simd + lane;
    return v[7:0];
  endfunction

  initial begin
    int idx;
    int toggles;
    int pulses;
    logic r;
    logic prev;

    // Reset
    tick(); tick();
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_a_mis",   a_mis,   0);
    check("rst_a_done",  a_done,  0);
    check("rst_a_err",   a_err,   0);
    check("rst_a_first", a_first, 32'hFFFF_FFFF);
    check("rst_a_fc",    a_fc,    0);
    rst = 1'b0;
    tick();
    check("a_ready_on", a_ready, 1);
    check("b_ready_seed", b_ready, exp_rdy_b);

    // A: ideal frame with hand values at beats 0..3, 6, 18
    a_valid = 1'b1;
    for (int i = 0; i < 72; i++) begin
      case (i)
        0: a_data = 8'd0;
        1: a_data = 8'd1;
        2: a_data = 8'd2;
        3: a_data = 8'd3;
        6: a_data = 8'd12;
        18: a_data = 8'd4;
        default: a_data = ramp(1, 2, 2, 0, 0, 2, i, 0);
      endcase
      tick();
      check("a1_mis", a_mis, 0);
      check("a1_done", a_done, (i == 71));
    end
    a_valid = 1'b0;
    check("a1_fc", a_fc, 1);
    check("a1_err", a_err, 0);
    check("a1_first", a_first, 32'hFFFF_FFFF);
    tick();
    check("a1_done_low", a_done, 0);

    // A: beat 5 corrupted
    a_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 72; i++) begin
      a_data = (i == 5) ? 8'h55 : ramp(1, 2, 2, 0, 0, 2, i, 0);
      tick();
      pulses += int'(a_mis);
      check("a2_mis", a_mis, (i == 5));
    end
    a_valid = 1'b0;
    check("a2_pulses", pulses, 1);
    check("a2_err", a_err, 1);
    check("a2_first", a_first, 5);
    check("a2_fc", a_fc, 2);

    // B: tvalid held high, three frames under LFSR backpressure
    b_valid = 1'b1;
    idx = 0;
    toggles = 0;
    prev = b_ready;
    for (int cyc = 0; cyc < 2000 && idx < 216; cyc++) begin
      b_data = ramp(1, 2, 2, 0, 0, 2, idx % 72, 0);
      r = b_ready;
      tick();
      if (r) idx++;
      if (b_ready != prev) toggles++;
      prev = b_ready;
      check("b_ready", b_ready, exp_rdy_b);
      check("b_mis", b_mis, 0);
    end
    b_valid = 1'b0;
    check("b_beats", idx, 216);
    check("b_toggled", (toggles > 0), 1);
    check("b_fc", b_fc, 3);
    check("b_err", b_err, 0);

    // C: padded, nonzero at out-of-map beat 0
    c_valid = 1'b1;
    for (int i = 0; i < 162; i++) begin
      case (i)
        0: c_data = 8'h07;
        8: c_data = 8'd0;
        9: c_data = 8'd1;
        default: c_data = ramp(1, 2, 2, 1, 1, 3, i, 0);
      endcase
      tick();
      check("c_mis", c_mis, (i == 0));
      check("c_done", c_done, (i == 161));
    end
    c_valid = 1'b0;
    check("c_err", c_err, 1);
    check("c_first", c_first, 0);
    check("c_fc", c_fc, 1);

    // D: SIMD 2, correct frame, then lane 1 of beat 1 wrong
    d_valid = 1'b1;
    for (int i = 0; i < 72; i++) begin
      case (i)
        0: d_data = 16'h0100;
        1: d_data = 16'h0302;
        default: d_data = {ramp(2, 4, 2, 0, 0, 2, i, 1), ramp(2, 4, 2, 0, 0, 2, i, 0)};
      endcase
      tick();
      check("d1_mis", d_mis, 0);
    end
    check("d1_fc", d_fc, 1);
    check("d1_err", d_err, 0);
    for (int i = 0; i < 72; i++) begin
      d_data = (i == 1) ? 16'h0202
                        : {ramp(2, 4, 2, 0, 0, 2, i, 1), ramp(2, 4, 2, 0, 0, 2, i, 0)};
      tick();
      check("d2_mis", d_mis, (i == 1));
    end
    d_valid = 1'b0;
    check("d2_err", d_err, 1);
    check("d2_first", d_first, 1);
    check("d2_fc", d_fc, 2);

    // A: reset after 40 beats, then a fresh frame
    a_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a_data = ramp(1, 2, 2, 0, 0, 2, i, 0);
      tick();
    end
    a_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("mr_ready", a_ready, 0);
    check("mr_fc", a_fc, 0);
    check("mr_err", a_err, 0);
    check("mr_first", a_first, 32'hFFFF_FFFF);
    rst = 1'b0;
    tick();
    a_valid = 1'b1;
    for (int i = 0; i < 72; i++) begin
      a_data = ramp(1, 2, 2, 0, 0, 2, i, 0);
      tick();
      check("mr_mis", a_mis, 0);
      check("mr_done", a_done, (i == 71));
    end
    a_valid = 1'b0;
    check("mr_fc_end", a_fc, 1);
    check("mr_err_end", a_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
